diff_scoreboard: RTL and testbench
==================================

Name: diff_scoreboard

Overview:
- Downstream consumer of the monitor stage's per-cycle difference vector (`i_diff`) and its ready flag.
- Runs a bounded test window with the following outputs:
  - total sample count;
  - failing-sample count;
  - sticky per-bit error mask;
  - pass/fail verdict.
- Logs each failing sample's index and diff vector into a small FIFO. Host logic drains the FIFO through a valid/ready handshake.

Parameters:
- WIDTH, 32, width of the diff vector; must match the monitor stage.
- CNT_W, 32, width of the sample and error counters; counters saturate at all-ones.
- LOG_DEPTH, 3, log2 of error FIFO depth (default 8 entries).

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous active-low reset; reset==0 at a rising edge of clk resets the block.
- i_mon_ready, input, 1, monitor valid flag; samples count only while high.
- i_diff, input, WIDTH, XOR difference from the monitor; non-zero means a failing sample.
- i_start, input, 1, one-cycle pulse that clears results and arms a run.
- i_stop, input, 1, one-cycle pulse that ends the run.
- o_busy, output, 1, high in WAIT_READY or RUN.
- o_done, output, 1, high in DONE.
- o_pass, output, 1, valid in DONE: err_cnt==0 and sample_cnt!=0.
- o_sample_cnt, output, CNT_W, number of samples taken this run.
- o_err_cnt, output, CNT_W, number of failing samples this run.
- o_sticky, output, WIDTH, OR of all i_diff values counted this run.
- o_overflow, output, 1, sticky flag: a failing sample was dropped because the FIFO was full.
- o_err_valid, output, 1, FIFO head valid.
- o_err_idx, output, CNT_W, sample index of the FIFO head.
- o_err_diff, output, WIDTH, diff vector of the FIFO head.
- i_err_ready, input, 1, consumer accepts the FIFO head.

Behaviour:
- Reset values:
  - state is IDLE;
  - all outputs are 0;
  - FIFO is empty.
- States are IDLE, WAIT_READY, RUN, DONE.
- IDLE / DONE:
  - i_start moves to WAIT_READY.
  - On that same edge, clear counters, sticky, overflow and the FIFO.
- WAIT_READY:
  - No sampling.
  - i_mon_ready==1 moves to RUN; the sample on that edge is not counted.
  - i_stop moves to DONE.
- RUN:
  - Each edge with i_mon_ready==1 is a sample.
  - idx = o_sample_cnt before increment.
  - sample_cnt increments.
  - If i_diff != 0: err_cnt increments, sticky |= i_diff, and {idx, i_diff} is pushed to the FIFO.
- RUN with i_mon_ready==0: no sample is taken and the state stays RUN. Gaps are not errors.
- RUN with i_stop moves to DONE. The sample on the stop edge is still counted.
- i_start while in RUN or WAIT_READY restarts: clear everything and go to WAIT_READY.
- Simultaneous i_start and i_stop: i_start wins.
- Latency: i_diff sampled at edge n is reflected in the counters, sticky and FIFO outputs after edge n (visible in cycle n+1).
- Counters saturate:
  - At all-ones, the count holds.
  - A saturated sample_cnt still records idx = all-ones.
- FIFO:
  - Registered and first-word-fall-through.
  - Pop occurs when o_err_valid && i_err_ready.
  - Push while full with no pop in the same cycle: entry dropped, o_overflow set (sticky until next i_start or reset). err_cnt still increments.
  - Push while full with a pop in the same cycle: push accepted, no overflow.
  - Push into an empty FIFO: o_err_valid rises the next cycle.
  - FIFO remains drainable in every state. i_start or reset discards its contents.
- o_pass is 0 outside DONE. A DONE with zero samples reports o_pass=0.
- Reset asserted mid-run: all state returns to reset values on that edge, with no partial results retained.

Decomposition:
- Shared header (scoreboard_defs.vh) holds:
  - state encodings ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RUN=2'd2, ST_DONE=2'd3;
  - default WIDTH, CNT_W and LOG_DEPTH values, reused by the monitor-level top.
- One sub-module, err_fifo:
  - parameters DATA_W and LOG_DEPTH;
  - ports: push, data, full, valid/ready pop, flush;
  - implemented with a pointer wrap bit for full/empty detection.
- Top level holds the FSM, counters, sticky mask and overflow flag.

Test Plan:
- Reset low for 2 cycles, then start; run 10 samples of i_diff=0 with ready high, then stop.
  Required: o_sample_cnt=10, o_err_cnt=0, o_sticky=0, o_pass=1, o_err_valid=0.
- Start; samples 0..5 with i_diff=0, 0x1, 0, 0x80000000, 0, 0x1; i_err_ready=1.
  Required: err_cnt=3 and sticky=0x80000001.
  Required FIFO output, in order: (idx1, 0x1), (idx3, 0x80000000), (idx5, 0x1).
- i_err_ready=0 with 10 consecutive failing samples (LOG_DEPTH=3).
  Required: FIFO holds idx 0..7, o_overflow=1, err_cnt=10.
  Required: after draining, valid drops after 8 pops.
- FIFO full, then a failing sample arrives on the same edge as a pop.
  Required: push accepted, o_overflow stays 0, occupancy stays 8.
- i_mon_ready held low for 5 cycles after start, then toggled 1,0,1.
  Required: state is WAIT_READY until ready is first high; sample_cnt=1 after the sequence.
- Mid-RUN with err_cnt=4: assert reset for 1 cycle.
  Required: all outputs 0 and state IDLE.
  Separately: i_start and i_stop together in RUN give a restart (WAIT_READY, counters 0).

Source files
------------

// File: rtl/diff_scoreboard_pkg.sv
// Shared definitions for the diff scoreboard: state encodings and default sizes
// reused by the monitor-level top.
package diff_scoreboard_pkg;

   localparam int DEF_WIDTH     = 32;
   localparam int DEF_CNT_W     = 32;
   localparam int DEF_LOG_DEPTH = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/diff_scoreboard_err_fifo.sv
// First-word-fall-through error log FIFO; pointers carry a wrap bit so that
// full and empty are told apart without a separate occupancy counter.
module err_fifo #(
   parameter int DATA_W    = 64,
   parameter int LOG_DEPTH = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] data,
   output logic              full,
   output logic              valid,
   output logic [DATA_W-1:0] q,
   input  logic              ready
);
   localparam int DEPTH = 1 << LOG_DEPTH;

   logic [DATA_W-1:0]  mem_q [DEPTH];
   logic [LOG_DEPTH:0] wr_ptr_q, wr_ptr_d;
   logic [LOG_DEPTH:0] rd_ptr_q, rd_ptr_d;
   logic               empty, pop, push_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]) &&
                    (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);
   assign pop     = !empty && ready;
   // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
   assign push_ok = push && (!full || pop);
   assign valid   = !empty;
   assign q       = empty ? '0 : mem_q[rd_ptr_q[LOG_DEPTH-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + (LOG_DEPTH+1)'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + (LOG_DEPTH+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem_q[wr_ptr_q[LOG_DEPTH-1:0]] <= data;
   end

endmodule

// File: rtl/diff_scoreboard.sv
// Scoreboard for the monitor's difference vector: run window FSM, saturating
// sample/error counters, sticky bit mask, verdict and a log of failing samples.
module diff_scoreboard
   import diff_scoreboard_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int LOG_DEPTH = DEF_LOG_DEPTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_mon_ready,
   input  logic [WIDTH-1:0] i_diff,
   input  logic             i_start,
   input  logic             i_stop,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_pass,
   output logic [CNT_W-1:0] o_sample_cnt,
   output logic [CNT_W-1:0] o_err_cnt,
   output logic [WIDTH-1:0] o_sticky,
   output logic             o_overflow,
   output logic             o_err_valid,
   output logic [CNT_W-1:0] o_err_idx,
   output logic [WIDTH-1:0] o_err_diff,
   input  logic             i_err_ready
);
   state_e             state_q, state_d;
   logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
   logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic [WIDTH-1:0]   sticky_q, sticky_d;
   logic               overflow_q, overflow_d;
   logic               clear, sample, failing;
   logic               fifo_full, fifo_push, fifo_pop;
   logic [CNT_W+WIDTH-1:0] fifo_q;

   assign failing   = |i_diff;
   assign fifo_push = sample && failing;
   assign fifo_pop  = o_err_valid && i_err_ready;

   always_comb begin
      state_d      = state_q;
      sample_cnt_d = sample_cnt_q;
      err_cnt_d    = err_cnt_q;
      sticky_d     = sticky_q;
      overflow_d   = overflow_q;
      clear        = 1'b0;
      sample       = 1'b0;

      // i_start wins over everything, including a coincident i_stop.
      case (state_q)
         ST_IDLE, ST_DONE: if (i_start) clear = 1'b1;
         ST_WAIT: begin
            if (i_start)          clear   = 1'b1;
            else if (i_stop)      state_d = ST_DONE;
            else if (i_mon_ready) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (i_start) clear = 1'b1;
            else begin
               sample = i_mon_ready;
               if (i_stop) state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (clear) begin
         state_d      = ST_WAIT;
         sample_cnt_d = '0;
         err_cnt_d    = '0;
         sticky_d     = '0;
         overflow_d   = 1'b0;
      end else if (sample) begin
         if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + CNT_W'(1);
         if (failing) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            sticky_d = sticky_q | i_diff;
            if (fifo_full && !fifo_pop) overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         sample_cnt_q <= '0;
         err_cnt_q    <= '0;
         sticky_q     <= '0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sample_cnt_q <= sample_cnt_d;
         err_cnt_q    <= err_cnt_d;
         sticky_q     <= sticky_d;
         overflow_q   <= overflow_d;
      end
   end

   err_fifo #(
      .DATA_W    (CNT_W + WIDTH),
      .LOG_DEPTH (LOG_DEPTH)
   ) u_err_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (clear),
      .push  (fifo_push),
      .data  ({sample_cnt_q, i_diff}),
      .full  (fifo_full),
      .valid (o_err_valid),
      .q     (fifo_q),
      .ready (i_err_ready)
   );

   assign o_busy       = (state_q == ST_WAIT) || (state_q == ST_RUN);
   assign o_done       = (state_q == ST_DONE);
   assign o_pass       = o_done && (err_cnt_q == '0) && (sample_cnt_q != '0);
   assign o_sample_cnt = sample_cnt_q;
   assign o_err_cnt    = err_cnt_q;
   assign o_sticky     = sticky_q;
   assign o_overflow   = overflow_q;
   assign o_err_idx    = fifo_q[WIDTH +: CNT_W];
   assign o_err_diff   = fifo_q[WIDTH-1:0];

endmodule

// File: tb/tb_diff_scoreboard.sv
// Self-checking bench for diff_scoreboard: per-scenario tasks plus a queue
// scoreboard that checks every FIFO entry handed to the consumer.
module tb_diff_scoreboard;
   import diff_scoreboard_pkg::*;

   localparam int WIDTH = 32;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             i_mon_ready;
   logic [WIDTH-1:0] i_diff;
   logic             i_start;
   logic             i_stop;
   logic             o_busy, o_done, o_pass, o_overflow, o_err_valid;
   logic [CNT_W-1:0] o_sample_cnt, o_err_cnt, o_err_idx;
   logic [WIDTH-1:0] o_sticky, o_err_diff;
   logic             i_err_ready;

   int checks   = 0;
   int failures = 0;
   logic [CNT_W+WIDTH-1:0] exp_q[$];

   diff_scoreboard dut (
      .clk          (clk),
      .reset        (reset),
      .i_mon_ready  (i_mon_ready),
      .i_diff       (i_diff),
      .i_start      (i_start),
      .i_stop       (i_stop),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_pass       (o_pass),
      .o_sample_cnt (o_sample_cnt),
      .o_err_cnt    (o_err_cnt),
      .o_sticky     (o_sticky),
      .o_overflow   (o_overflow),
      .o_err_valid  (o_err_valid),
      .o_err_idx    (o_err_idx),
      .o_err_diff   (o_err_diff),
      .i_err_ready  (i_err_ready)
   );

   always #5 clk = ~clk;

   // Handshake observed mid-cycle; the pop itself happens on the next rising edge.
   always @(negedge clk) begin
      if (reset && o_err_valid && i_err_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL fifo_pop unexpected: got idx=%0d diff=%h, required none", o_err_idx, o_err_diff);
         end else begin
            if ({o_err_idx, o_err_diff} !== exp_q[0]) begin
               failures++;
               $display("FAIL fifo_pop: got idx=%0d diff=%h, required idx=%0d diff=%h",
                        o_err_idx, o_err_diff, exp_q[0][CNT_W+WIDTH-1:WIDTH], exp_q[0][WIDTH-1:0]);
            end else begin
               $display("pop idx=%0d diff=%h", o_err_idx, o_err_diff);
            end
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic start_run();
      i_err_ready = 1'b0;
      exp_q.delete();
      i_start = 1'b1;
      cycle();
      i_start = 1'b0;
   endtask

   task automatic enter_run();
      i_mon_ready = 1'b1;
      i_diff      = '0;
      cycle();
   endtask

   task automatic idle_inputs();
      i_mon_ready = 1'b0;
      i_diff      = '0;
      i_stop      = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; i_start = 1'b0; i_err_ready = 1'b0;
      idle_inputs();
      cycle(); cycle();
      checks++;
      if ({o_busy, o_done, o_pass, o_overflow, o_err_valid} !== 5'b0 ||
          o_sample_cnt !== '0 || o_err_cnt !== '0 || o_sticky !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got flags=%b samples=%0d errs=%0d sticky=%h, required all 0",
                  {o_busy, o_done, o_pass, o_overflow, o_err_valid}, o_sample_cnt, o_err_cnt, o_sticky);
      end
      checks++;
      if (dut.state_q !== ST_IDLE) begin
         failures++;
         $display("FAIL reset_state: got %0d, required %0d", dut.state_q, ST_IDLE);
      end
      reset = 1'b1;
      $display("reset done");
   endtask

   task automatic test_pass_run();
      start_run();
      checks++;
      if (o_busy !== 1'b1 || o_done !== 1'b0) begin
         failures++;
         $display("FAIL pass_busy: got busy=%b done=%b, required 1 0", o_busy, o_done);
      end
      enter_run();
      for (int i = 0; i < 10; i++) begin
         i_stop = (i == 9);
         cycle();
      end
      idle_inputs();
      checks++;
      if (o_sample_cnt !== 32'd10 || o_err_cnt !== '0 || o_sticky !== '0 ||
          o_pass !== 1'b1 || o_done !== 1'b1 || o_err_valid !== 1'b0) begin
         failures++;
         $display("FAIL pass_run: got samples=%0d errs=%0d sticky=%h pass=%b done=%b valid=%b, required 10 0 0 1 1 0",
                  o_sample_cnt, o_err_cnt, o_sticky, o_pass, o_done, o_err_valid);
      end
      $display("pass run samples=%0d pass=%b", o_sample_cnt, o_pass);
   endtask

   task automatic test_err_log();
      logic [WIDTH-1:0] pat [6];
      pat = '{32'h0, 32'h1, 32'h0, 32'h8000_0000, 32'h0, 32'h1};
      start_run();
      i_err_ready = 1'b1;
      enter_run();
      for (int i = 0; i < 6; i++) begin
         i_diff = pat[i];
         i_stop = (i == 5);
         if (pat[i] != 0) exp_q.push_back({CNT_W'(i), pat[i]});
         cycle();
      end
      idle_inputs();
      checks++;
      if (o_err_cnt !== 32'd3 || o_sticky !== 32'h8000_0001 || o_pass !== 1'b0) begin
         failures++;
         $display("FAIL err_log_counts: got errs=%0d sticky=%h pass=%b, required 3 80000001 0",
                  o_err_cnt, o_sticky, o_pass);
      end
      for (int k = 0; k < 20 && (o_err_valid || exp_q.size() != 0); k++) cycle();
      checks++;
      if (exp_q.size() != 0 || o_err_valid !== 1'b0) begin
         failures++;
         $display("FAIL err_log_drain: got left=%0d valid=%b, required 0 0", exp_q.size(), o_err_valid);
      end
      $display("err log errs=%0d sticky=%h", o_err_cnt, o_sticky);
   endtask

   task automatic test_overflow();
      int pops;
      start_run();
      enter_run();
      for (int i = 0; i < 10; i++) begin
         i_diff = WIDTH'(i + 1);
         i_stop = (i == 9);
         if (i < 8) exp_q.push_back({CNT_W'(i), WIDTH'(i + 1)});
         cycle();
      end
      idle_inputs();
      checks++;
      if (o_overflow !== 1'b1 || o_err_cnt !== 32'd10 || o_err_valid !== 1'b1) begin
         failures++;
         $display("FAIL overflow_flags: got ovf=%b errs=%0d valid=%b, required 1 10 1",
                  o_overflow, o_err_cnt, o_err_valid);
      end
      i_err_ready = 1'b1;
      pops = 0;
      for (int k = 0; k < 20 && o_err_valid; k++) begin
         pops++;
         cycle();
      end
      checks++;
      if (pops != 8 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL overflow_drain: got pops=%0d left=%0d, required 8 0", pops, exp_q.size());
      end
      $display("overflow drained pops=%0d", pops);
   endtask

   task automatic test_full_pop();
      int pops;
      start_run();
      enter_run();
      for (int i = 0; i < 9; i++) begin
         i_diff = WIDTH'(32'h100 + i);
         i_stop = (i == 8);
         i_err_ready = (i == 8);
         exp_q.push_back({CNT_W'(i), WIDTH'(32'h100 + i)});
         cycle();
      end
      idle_inputs();
      checks++;
      if (o_overflow !== 1'b0 || o_err_cnt !== 32'd9) begin
         failures++;
         $display("FAIL full_pop_ovf: got ovf=%b errs=%0d, required 0 9", o_overflow, o_err_cnt);
      end
      pops = 0;
      for (int k = 0; k < 20 && o_err_valid; k++) begin
         pops++;
         cycle();
      end
      checks++;
      if (pops != 8 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL full_pop_occupancy: got pops=%0d left=%0d, required 8 0", pops, exp_q.size());
      end
      $display("full+pop occupancy=%0d", pops);
   endtask

   task automatic test_gaps();
      int bad;
      start_run();
      bad = 0;
      i_mon_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         if (dut.state_q !== ST_WAIT || o_sample_cnt !== '0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL gaps_wait: got %0d bad cycles, required 0", bad);
      end
      i_mon_ready = 1'b1; cycle();
      i_mon_ready = 1'b0; cycle();
      i_mon_ready = 1'b1; cycle();
      i_mon_ready = 1'b0;
      checks++;
      if (o_sample_cnt !== 32'd1 || dut.state_q !== ST_RUN) begin
         failures++;
         $display("FAIL gaps_count: got samples=%0d state=%0d, required 1 %0d",
                  o_sample_cnt, dut.state_q, ST_RUN);
      end
      i_stop = 1'b1; cycle();
      idle_inputs();
      $display("gaps samples=%0d", o_sample_cnt);
   endtask

   task automatic test_reset_mid_run();
      start_run();
      enter_run();
      for (int i = 0; i < 4; i++) begin
         i_diff = 32'hF0 >> i;
         cycle();
      end
      i_diff = '0;
      checks++;
      if (o_err_cnt !== 32'd4 || o_sample_cnt !== 32'd4) begin
         failures++;
         $display("FAIL mid_run_pre: got errs=%0d samples=%0d, required 4 4", o_err_cnt, o_sample_cnt);
      end
      reset = 1'b0;
      cycle();
      reset = 1'b1;
      idle_inputs();
      exp_q.delete();
      checks++;
      if ({o_busy, o_done, o_pass, o_overflow, o_err_valid} !== 5'b0 ||
          o_sample_cnt !== '0 || o_err_cnt !== '0 || o_sticky !== '0 || dut.state_q !== ST_IDLE) begin
         failures++;
         $display("FAIL mid_run_reset: got flags=%b samples=%0d errs=%0d sticky=%h state=%0d, required all 0",
                  {o_busy, o_done, o_pass, o_overflow, o_err_valid}, o_sample_cnt, o_err_cnt, o_sticky, dut.state_q);
      end
      $display("mid-run reset state=%0d", dut.state_q);
   endtask

   task automatic test_start_stop();
      start_run();
      enter_run();
      for (int i = 0; i < 3; i++) cycle();
      checks++;
      if (o_sample_cnt !== 32'd3) begin
         failures++;
         $display("FAIL start_stop_pre: got samples=%0d, required 3", o_sample_cnt);
      end
      i_start = 1'b1; i_stop = 1'b1; i_diff = 32'h5;
      cycle();
      i_start = 1'b0;
      idle_inputs();
      checks++;
      if (dut.state_q !== ST_WAIT || o_sample_cnt !== '0 || o_err_cnt !== '0 ||
          o_sticky !== '0 || o_err_valid !== 1'b0 || o_busy !== 1'b1) begin
         failures++;
         $display("FAIL start_stop: got state=%0d samples=%0d errs=%0d sticky=%h valid=%b busy=%b, required %0d 0 0 0 0 1",
                  dut.state_q, o_sample_cnt, o_err_cnt, o_sticky, o_err_valid, o_busy, ST_WAIT);
      end
      $display("start+stop restart state=%0d", dut.state_q);
   endtask

   initial begin
      test_reset();
      test_pass_run();
      test_err_log();
      test_overflow();
      test_full_pop();
      test_gaps();
      test_reset_mid_run();
      test_start_stop();
      repeat (2) cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
